hazard_ctrl: RTL and testbench

- Pipeline hazard and flush controller.
- Drives the stall and flush controls of the IF/ID and ID/EX pipeline registers, the PC stall, and an EX/MEM hold.
- Resolves three hazard sources:
  - load-use hazards, by inserting a bubble;
  - taken branches/jumps resolved in EX, by flushing the wrong-path instructions;
  - multi-cycle data-memory accesses, by freezing the whole pipeline.
- Keeps saturating performance counters for stall cycles and flush events.

---
 rtl/hazard_ctrl_pkg.sv | 14 +
 rtl/hazard_ctrl_sat_counter.sv | 31 +++
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM encodings and register-index constants.
package hazard_ctrl_pkg;

   localparam int REG_W = 6;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      LOAD_BUBBLE = 2'd1,
      BR_SHADOW   = 2'd2,
      MEM_WAIT    = 2'd3
   } hazard_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear; clear has priority over increment.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/flush controller: load-use bubbles, taken-branch flush shadow and memory freeze,
// with saturating stall-cycle and flush-event counters.
module hazard_ctrl #(
   parameter int REG_W        = 6,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_br_taken,
   input  logic             mem_busy,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_stall,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   import hazard_ctrl_pkg::*;

   hazard_state_e state_q, state_d;
   logic [2:0]    shadow_q, shadow_d;

   logic load_use;
   logic in_shadow;
   logic flush_evt;
   logic pc_stall_c, if_id_stall_c, if_id_flush_c;
   logic id_ex_stall_c, id_ex_flush_c, ex_mem_stall_c;

   assign load_use = ex_mem_read && (ex_rd != REG_W'(REG_ZERO)) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

   // A freeze that interrupted the branch shadow leaves a non-zero count behind; resume from it.
   assign in_shadow = (state_q == BR_SHADOW) || ((state_q == MEM_WAIT) && (shadow_q != 3'd0));

   always_comb begin
      state_d        = state_q;
      shadow_d       = shadow_q;
      flush_evt      = 1'b0;
      pc_stall_c     = 1'b0;
      if_id_stall_c  = 1'b0;
      if_id_flush_c  = 1'b0;
      id_ex_stall_c  = 1'b0;
      id_ex_flush_c  = 1'b0;
      ex_mem_stall_c = 1'b0;
      if (mem_busy) begin
         pc_stall_c     = 1'b1;
         if_id_stall_c  = 1'b1;
         id_ex_stall_c  = 1'b1;
         ex_mem_stall_c = 1'b1;
         state_d        = MEM_WAIT;
      end else if (ex_br_taken) begin
         if_id_flush_c = 1'b1;
         id_ex_flush_c = 1'b1;
         flush_evt     = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            shadow_d = 3'(FLUSH_CYCLES - 1);
            state_d  = BR_SHADOW;
         end else begin
            shadow_d = 3'd0;
            state_d  = RUN;
         end
      end else if (in_shadow) begin
         if_id_flush_c = 1'b1;
         id_ex_flush_c = 1'b1;
         shadow_d      = shadow_q - 3'd1;
         state_d       = (shadow_q == 3'd1) ? RUN : BR_SHADOW;
      end else if (load_use && (state_q != LOAD_BUBBLE)) begin
         pc_stall_c    = 1'b1;
         if_id_stall_c = 1'b1;
         id_ex_flush_c = 1'b1;
         state_d       = LOAD_BUBBLE;
      end else begin
         state_d = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         shadow_q <= 3'd0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
      end
   end

   assign pc_stall     = pc_stall_c & ~rst;
   assign if_id_stall  = if_id_stall_c & ~rst;
   assign if_id_flush  = if_id_flush_c & ~rst;
   assign id_ex_stall  = id_ex_stall_c & ~rst;
   assign id_ex_flush  = id_ex_flush_c & ~rst;
   assign ex_mem_stall = ex_mem_stall_c & ~rst;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i   (clk),
      .inc_i   (pc_stall),
      .clr_i   (rst),
      .count_o (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i   (clk),
      .inc_i   (flush_evt & ~rst),
      .clr_i   (rst),
      .count_o (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: two instances (FLUSH_CYCLES=3/CNT_W=4 and FLUSH_CYCLES=4/CNT_W=16)
// share one stimulus; expected control vectors are queued at drive time and popped when sampled.
module tb_hazard_ctrl;

   localparam logic [5:0] IDLE     = 6'b000000;
   localparam logic [5:0] STALL_LU = 6'b110010;
   localparam logic [5:0] FLUSH    = 6'b001010;
   localparam logic [5:0] FREEZE   = 6'b110101;

   typedef struct {
      logic       sel4;
      logic [5:0] ctrl;
      string      tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_br_taken, mem_busy;

   logic        pcS3, ifS3, ifF3, idS3, idF3, emS3;
   logic [3:0]  stallCnt3, flushCnt3;
   logic        pcS4, ifS4, ifF4, idS4, idF4, emS4;
   logic [15:0] stallCnt4, flushCnt4;

   logic [5:0] ctrl3, ctrl4, obs;
   exp_t       expQ[$];
   exp_t       e;
   int         checks = 0;
   int         errors = 0;

   assign ctrl3 = {pcS3, ifS3, ifF3, idS3, idF3, emS3};
   assign ctrl4 = {pcS4, ifS4, ifF4, idS4, idF4, emS4};

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_W(6), .FLUSH_CYCLES(3), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
      .pc_stall(pcS3), .if_id_stall(ifS3), .if_id_flush(ifF3), .id_ex_stall(idS3),
      .id_ex_flush(idF3), .ex_mem_stall(emS3), .stall_cnt(stallCnt3), .flush_cnt(flushCnt3)
   );

   hazard_ctrl #(.REG_W(6), .FLUSH_CYCLES(4), .CNT_W(16)) dut4 (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
      .pc_stall(pcS4), .if_id_stall(ifS4), .if_id_flush(ifF4), .id_ex_stall(idS4),
      .id_ex_flush(idF4), .ex_mem_stall(emS4), .stall_cnt(stallCnt4), .flush_cnt(flushCnt4)
   );

   // Drives one cycle of inputs just after the falling edge and queues the control vector it should produce.
   task automatic applyStimulus(input logic [5:0] rs1, input logic [5:0] rs2, input logic u1,
                                input logic u2, input logic [5:0] rd, input logic mr, input logic br,
                                input logic busy, input logic sel4, input logic [5:0] expCtrl,
                                input string tag);
      exp_t x;
      @(negedge clk);
      id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
      ex_rd = rd; ex_mem_read = mr; ex_br_taken = br; mem_busy = busy;
      x.sel4 = sel4; x.ctrl = expCtrl; x.tag = tag;
      expQ.push_back(x);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_rd = '0; ex_mem_read = 1'b0; ex_br_taken = 1'b0; mem_busy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      ex_br_taken = 1'b1; mem_busy = 1'b1;
      #2;
      checks++;
      if (ctrl3 !== IDLE) begin
         errors++; $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl3, IDLE);
      end
      @(posedge clk); #1;
      checks++;
      if (stallCnt3 !== 4'd0 || flushCnt3 !== 4'd0) begin
         errors++; $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", stallCnt3, flushCnt3);
      end
      doReset();
   endtask

   task automatic test_load_use();
      logic [5:0] want[3] = '{STALL_LU, IDLE, STALL_LU};
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(6'd5, 6'd9, 1'b1, 1'b0, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, want[i], "load_use");
         #2; e = expQ.pop_front(); obs = e.sel4 ? ctrl4 : ctrl3; checks++;
         if (obs !== e.ctrl) begin
            errors++; $display("[TB] FAIL %s[%0d]: got %b expected %b", e.tag, i, obs, e.ctrl);
         end
         if (i == 1) begin
            checks++;
            if (stallCnt3 !== 4'd1) begin
               errors++; $display("[TB] FAIL load_use_cnt: got %0d expected 1", stallCnt3);
            end
         end
      end
   endtask

   task automatic test_x0_unused();
      doReset();
      applyStimulus(6'd0, 6'd0, 1'b1, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, "x0_no_hazard");
      #2; e = expQ.pop_front(); obs = e.sel4 ? ctrl4 : ctrl3; checks++;
      if (obs !== e.ctrl) begin
         errors++; $display("[TB] FAIL %s: got %b expected %b", e.tag, obs, e.ctrl);
      end
      applyStimulus(6'd3, 6'd7, 1'b1, 1'b0, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, "rs2_unused");
      #2; e = expQ.pop_front(); obs = e.sel4 ? ctrl4 : ctrl3; checks++;
      if (obs !== e.ctrl) begin
         errors++; $display("[TB] FAIL %s: got %b expected %b", e.tag, obs, e.ctrl);
      end
      applyStimulus(6'd3, 6'd7, 1'b1, 1'b1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0, STALL_LU, "rs2_used");
      #2; e = expQ.pop_front(); obs = e.sel4 ? ctrl4 : ctrl3; checks++;
      if (obs !== e.ctrl) begin
         errors++; $display("[TB] FAIL %s: got %b expected %b", e.tag, obs, e.ctrl);
      end
   endtask

   task automatic test_branch();
      logic [5:0] want1[4] = '{FLUSH, FLUSH, FLUSH, IDLE};
      logic       br2[6]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [5:0] want2[6] = '{FLUSH, FLUSH, FLUSH, FLUSH, FLUSH, IDLE};
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, (i == 0), 1'b0, 1'b0, want1[i], "branch_single");
         #2; e = expQ.pop_front(); obs = e.sel4 ? ctrl4 : ctrl3; checks++;
         if (obs !== e.ctrl) begin
            errors++; $display("[TB] FAIL %s[%0d]: got %b expected %b", e.tag, i, obs, e.ctrl);
         end
      end
      checks++;
      if (flushCnt3 !== 4'd1) begin
         errors++; $display("[TB] FAIL branch_single_cnt: got %0d expected 1", flushCnt3);
      end
      doReset();
      for (int i = 0; i < 6; i++) begin
         applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, br2[i], 1'b0, 1'b0, want2[i], "branch_reload");
         #2; e = expQ.pop_front(); obs = e.sel4 ? ctrl4 : ctrl3; checks++;
         if (obs !== e.ctrl) begin
            errors++; $display("[TB] FAIL %s[%0d]: got %b expected %b", e.tag, i, obs, e.ctrl);
         end
      end
      checks++;
      if (flushCnt3 !== 4'd2 || stallCnt3 !== 4'd0) begin
         errors++; $display("[TB] FAIL branch_reload_cnt: got %0d/%0d expected 2/0", flushCnt3, stallCnt3);
      end
   endtask

   task automatic test_mem_freeze();
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(6'd5, '0, 1'b1, 1'b0, 6'd5, 1'b1, 1'b1, (i < 4), 1'b0,
                       (i < 4) ? FREEZE : FLUSH, "mem_freeze");
         #2; e = expQ.pop_front(); obs = e.sel4 ? ctrl4 : ctrl3; checks++;
         if (obs !== e.ctrl) begin
            errors++; $display("[TB] FAIL %s[%0d]: got %b expected %b", e.tag, i, obs, e.ctrl);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (flushCnt3 !== 4'd1 || stallCnt3 !== 4'd4) begin
         errors++; $display("[TB] FAIL mem_freeze_cnt: got %0d/%0d expected 1/4", flushCnt3, stallCnt3);
      end
   endtask

   task automatic test_shadow_resume();
      logic       busy[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [5:0] want[6] = '{FLUSH, FLUSH, FREEZE, FREEZE, FLUSH, IDLE};
      doReset();
      for (int i = 0; i < 6; i++) begin
         applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, (i == 0), busy[i], 1'b0, want[i], "shadow_resume");
         #2; e = expQ.pop_front(); obs = e.sel4 ? ctrl4 : ctrl3; checks++;
         if (obs !== e.ctrl) begin
            errors++; $display("[TB] FAIL %s[%0d]: got %b expected %b", e.tag, i, obs, e.ctrl);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] want[5] = '{STALL_LU, FLUSH, FLUSH, FLUSH, STALL_LU};
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(6'd4, '0, 1'b1, 1'b0, 6'd4, 1'b1, (i == 1), 1'b0, 1'b0, want[i], "bubble_branch");
         #2; e = expQ.pop_front(); obs = e.sel4 ? ctrl4 : ctrl3; checks++;
         if (obs !== e.ctrl) begin
            errors++; $display("[TB] FAIL %s[%0d]: got %b expected %b", e.tag, i, obs, e.ctrl);
         end
      end
      checks++;
      if (flushCnt3 !== 4'd1 || stallCnt3 !== 4'd1) begin
         errors++; $display("[TB] FAIL bubble_branch_cnt: got %0d/%0d expected 1/1", flushCnt3, stallCnt3);
      end
   endtask

   task automatic test_saturation();
      doReset();
      for (int i = 0; i < 20; i++) begin
         applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, FREEZE, "saturation");
         #2; e = expQ.pop_front(); obs = e.sel4 ? ctrl4 : ctrl3; checks++;
         if (obs !== e.ctrl) begin
            errors++; $display("[TB] FAIL %s[%0d]: got %b expected %b", e.tag, i, obs, e.ctrl);
         end
         if (i == 10) begin
            checks++;
            if (stallCnt3 !== 4'd10) begin
               errors++; $display("[TB] FAIL sat_mid: got %0d expected 10", stallCnt3);
            end
         end
      end
      @(posedge clk); #1;
      checks++;
      if (stallCnt3 !== 4'd15 || stallCnt4 !== 16'd20) begin
         errors++; $display("[TB] FAIL sat_end: got %0d/%0d expected 15/20", stallCnt3, stallCnt4);
      end
   endtask

   task automatic test_reset_mid_shadow();
      doReset();
      applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, FLUSH, "rms_branch");
      #2; e = expQ.pop_front(); obs = e.sel4 ? ctrl4 : ctrl3; checks++;
      if (obs !== e.ctrl) begin
         errors++; $display("[TB] FAIL %s: got %b expected %b", e.tag, obs, e.ctrl);
      end
      applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, FLUSH, "rms_shadow1");
      #2; e = expQ.pop_front(); obs = e.sel4 ? ctrl4 : ctrl3; checks++;
      if (obs !== e.ctrl) begin
         errors++; $display("[TB] FAIL %s: got %b expected %b", e.tag, obs, e.ctrl);
      end
      applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, IDLE, "rms_in_reset");
      rst = 1'b1;
      #2; e = expQ.pop_front(); obs = e.sel4 ? ctrl4 : ctrl3; checks++;
      if (obs !== e.ctrl) begin
         errors++; $display("[TB] FAIL %s: got %b expected %b", e.tag, obs, e.ctrl);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, IDLE, "rms_after");
         rst = 1'b0;
         #2; e = expQ.pop_front(); obs = e.sel4 ? ctrl4 : ctrl3; checks++;
         if (obs !== e.ctrl) begin
            errors++; $display("[TB] FAIL %s[%0d]: got %b expected %b", e.tag, i, obs, e.ctrl);
         end
      end
      checks++;
      if (flushCnt4 !== 16'd0 || stallCnt4 !== 16'd0) begin
         errors++; $display("[TB] FAIL rms_cnt: got %0d/%0d expected 0/0", flushCnt4, stallCnt4);
      end
   endtask

   initial begin
      rst = 1'b1;
      id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_rd = '0; ex_mem_read = 1'b0; ex_br_taken = 1'b0; mem_busy = 1'b0;
      test_reset();
      test_load_use();
      test_x0_unused();
      test_branch();
      test_mem_freeze();
      test_shadow_resume();
      test_back_to_back();
      test_saturation();
      test_reset_mid_shadow();
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
